// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period of a slow asynchronous input in clkIn cycles
// and reports each result over a valid/ack handshake. Define PERIOD_METER_HIGHTIME_EN
// to also report the high-phase length of each period on highTime.
module clk_period_meter #(
  parameter int CNT_W   = 26,
  parameter int TIMEOUT = 50000000
) (
  input  logic             clkIn,
  input  logic             resetN,
  input  logic             sigIn,
  input  logic             enable,
  output logic [CNT_W-1:0] period,
  output logic             periodValid,
  input  logic             periodAck,
  output logic             overrun,
  output logic             timeout
`ifdef PERIOD_METER_HIGHTIME_EN
  ,
  output logic [CNT_W-1:0] highTime
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEASURE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;
`ifdef PERIOD_METER_HIGHTIME_EN
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             fall;
`endif

  logic rise;
  logic new_result;
  logic ack_accept;

  always_comb begin
    sync1_d    = sigIn;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    rise       = sync2_q & ~prev_q;
    ack_accept = periodAck & valid_q;

    state_d    = state_q;
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
    new_result = 1'b0;

    // Disabling wins over everything: results in flight are dropped, not reported.
    if (!enable) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d   = '0;
          state_d = ST_ARM;
        end
        ST_ARM: begin
          cnt_d = '0;
          if (rise) begin
            cnt_d   = CNT_ONE;
            state_d = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (rise) begin
            new_result = 1'b1;
            cnt_d      = CNT_ONE;
            timeout_d  = 1'b0;
          end else if (cnt_q == CNT_TIMEOUT) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = ST_ARM;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    period_d  = new_result ? cnt_q : period_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (new_result) begin
      valid_d = 1'b1;
      // An ack landing with the new result consumed the old one: no loss to flag.
      if (valid_q && !periodAck) begin
        overrun_d = 1'b1;
      end
    end else if (ack_accept) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

`ifdef PERIOD_METER_HIGHTIME_EN
  always_comb begin
    fall        = ~sync2_q & prev_q;
    hi_cnt_d    = hi_cnt_q;
    high_time_d = new_result ? hi_cnt_q : high_time_q;
    if (enable && (state_q == ST_MEASURE) && fall) begin
      hi_cnt_d = cnt_q;
    end
  end
`endif

  always_ff @(posedge clkIn or negedge resetN) begin
    if (!resetN) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      prev_q      <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef PERIOD_METER_HIGHTIME_EN
      hi_cnt_q    <= '0;
      high_time_q <= '0;
`endif
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
`ifdef PERIOD_METER_HIGHTIME_EN
      hi_cnt_q    <= hi_cnt_d;
      high_time_q <= high_time_d;
`endif
    end
  end

  assign period      = period_q;
  assign periodValid = valid_q;
  assign overrun     = overrun_q;
  assign timeout     = timeout_q;
`ifdef PERIOD_METER_HIGHTIME_EN
  assign highTime    = high_time_q;
`endif

endmodule

// File: doc/clk_period_meter.md
# clk_period_meter

Measures the period of a slow, asynchronous square-wave input in units of the system clock and reports each result over a valid/ack handshake. It is the receiving end of the processor's divided-clock outputs: it closes the loop on generated strobes (e.g. the 10 kHz tick) and on external slow signals, so firmware and debug logic can read an actual frequency. It also flags a missing signal (timeout) and unread results that were overwritten (overrun).

## Interface
- CNT_W, 26, width of the period counter and result.
- TIMEOUT, 50000000, cycles without a rising edge before timeout; must be < 2^CNT_W and >= 2.
- clkIn  in  1  system clock; all logic on its rising edge.
- resetN  in  1  asynchronous, active-low reset.
- sigIn  in  1  asynchronous input being measured.
- enable  in  1  1 = measure, 0 = idle.
- period  out  CNT_W  last measured period in clkIn cycles, rising edge to rising edge.
- periodValid  out  1  new result available; held until acked.
- periodAck  in  1  consumer acknowledge; sampled on each clkIn edge.
- overrun  out  1  sticky; a result replaced an unacked one.
- timeout  out  1  sticky; no rising edge for TIMEOUT cycles.
- highTime  out  CNT_W  high-phase length in cycles (only with PERIOD_METER_HIGHTIME_EN).

## Operation
- Input path: two-flop synchronizer on sigIn, then a third register. The rising-edge strobe `rise` = sync & ~prev; falling strobe `fall` = ~sync & prev.
- FSM states:
  - IDLE: cnt = 0. Enters ARM when enable = 1.
  - ARM: cnt = 0. On `rise`, cnt <= 1 and go to MEASURE.
  - MEASURE: each cycle without `rise`, cnt <= cnt + 1.
    - On `rise`: period <= cnt, cnt <= 1, periodValid <= 1, timeout <= 0.
    - If cnt == TIMEOUT and there is no `rise`: timeout <= 1, cnt <= 0, go to ARM.
- enable = 0 in any state: go to IDLE next cycle, cnt <= 0, timeout <= 0. period, periodValid and overrun keep their values.
- Handshake:
  - periodValid clears on the cycle after periodAck = 1 is sampled while valid.
  - periodAck while valid = 0 is ignored.
- A new result while valid = 1 and periodAck = 0: period is overwritten, valid stays 1, overrun <= 1.
- Ack and new result in the same cycle: the new value loads, valid stays 1, overrun is unchanged.
- overrun clears on any accepted ack with no overwrite in that cycle.
- Arithmetic: cnt never exceeds TIMEOUT, so no wrap occurs.
- Reset values: all outputs 0, cnt 0, sync registers 0, state IDLE. Reset asserted mid-measurement discards the partial count immediately.

## Timing
- sigIn edge to `rise`: 2–3 clkIn cycles of synchronizer latency. This latency is constant across edges, so period is exact for a stable input.
- `rise` to periodValid/period update: 1 cycle (registered).
- After enable rises, the first valid result needs two rising edges of sigIn.
- Minimum measurable period is 2 cycles. Narrower pulses may be missed by the synchronizer; this is not detected.
- Timeout asserts TIMEOUT cycles after the last `rise`, registered one cycle later.

## Configuration
- PERIOD_METER_HIGHTIME_EN defined:
  - In MEASURE, `fall` latches cnt into an internal hiCnt.
  - On `rise`, highTime <= hiCnt, updated together with period.
  - highTime resets to 0.
- PERIOD_METER_HIGHTIME_EN undefined: the highTime port and hiCnt do not exist; all other behaviour is identical.

## Test plan
- 10 kHz reference: sigIn toggles every 5001 cycles, enable = 1 → second rising edge gives periodValid = 1, period = 10002. With the macro, highTime = 5001.
- Handshake: pulse periodAck for 1 cycle while valid → valid = 0 next cycle. The next edge gives valid = 1 with the same period and overrun = 0.
- Overrun: never ack across two results → overrun = 1, period holds the latest value. Ack → overrun = 0, valid = 0.
- Timeout: TIMEOUT = 100, one rising edge then sigIn held low → timeout = 1 at about 101 cycles, state ARM. Restart the input → after two edges valid = 1 and timeout = 0.
- Reset mid-measure: assert resetN = 0 asynchronously in MEASURE → all outputs 0 without waiting for a clock edge. Release → first result only after two new edges.
- Enable drop: enable = 0 in MEASURE → IDLE, timeout cleared, period and valid retained. Re-enable → a correct period after two edges.
